// File: rtl/booth_bcd_conv_pkg.sv
// Shared types and constants for the Booth-product to BCD conversion stage.
package booth_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Smallest digit count d with 10^d > 2^(w-1), i.e. enough for |most negative product|.
  function automatic int unsigned bcd_digits(input int unsigned w);
    longint unsigned lim;
    longint unsigned pw;
    int unsigned     d;
    lim = 64'd1 << (w - 1);
    pw  = 64'd1;
    d   = 0;
    while (pw <= lim) begin
      pw = pw * 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/booth_bcd_conv_bcd_digit_adj.sv
// Double-dabble digit-adjust cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import booth_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/booth_bcd_conv.sv
// Signed product to sign + packed BCD magnitude, one product bit per clock.
// Optional LZ_BLANK_EN adds the leading-zero blanking output oBlank.
module booth_bcd_conv
  import booth_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 5
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [2*N-1:0]            iProduct,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Sign,
  output logic [BCD_W*DIGITS-1:0]   oBCD
`ifdef LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]         oBlank
`endif
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned BW = BCD_W * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  if (DIGITS < bcd_digits(W)) begin : g_digits_check
    $error("booth_bcd_conv: DIGITS too small for product width");
  end

  state_e          state_q;
  logic            start_q;
  logic            busy_q;
  logic            done_q;
  logic            sign_q;
  logic [W-1:0]    mag_q;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   obcd_q;
  logic [CW-1:0]   cnt_q;

  logic            start_rise;
  logic [W-1:0]    mag_d;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_d;

  assign start_rise = Start & ~start_q;

  always_comb begin
    mag_d = iProduct[W-1] ? (~iProduct + W'(1)) : iProduct;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[g*BCD_W +: BCD_W]),
      .digit_o (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    bcd_d = {bcd_adj[BW-2:0], mag_q[W-1]};
  end

`ifdef LZ_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              zero_run;

  // Walk from the top digit down; digit 0 is never blanked so zero still shows.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (bcd_d[i*BCD_W +: BCD_W] == '0);
      blank_d[i] = zero_run;
    end
  end

  assign oBlank = blank_q;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      obcd_q  <= '0;
      cnt_q   <= '0;
`ifdef LZ_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      start_q <= Start;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_rise) begin
            sign_q  <= iProduct[W-1];
            mag_q   <= mag_d;
            bcd_q   <= '0;
            cnt_q   <= CW'(W);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= {mag_q[W-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            obcd_q  <= bcd_d;
`ifdef LZ_BLANK_EN
            blank_q <= blank_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sign = sign_q;
  assign oBCD = obcd_q;

endmodule

// File: tb/tb_booth_bcd_conv.sv
// Self-checking bench for booth_bcd_conv against a decimal arithmetic reference.
module tb_booth_bcd_conv;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] iProduct;
  logic        Busy;
  logic        Done;
  logic        Sign;
  logic [19:0] oBCD;
`ifdef LZ_BLANK_EN
  logic [4:0]  oBlank;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [19:0] prev_bcd;

  always #5 Clock = ~Clock;

  booth_bcd_conv #(
    .N      (8),
    .DIGITS (5)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .iProduct (iProduct),
    .Busy     (Busy),
    .Done     (Done),
    .Sign     (Sign),
    .oBCD     (oBCD)
`ifdef LZ_BLANK_EN
    ,
    .oBlank   (oBlank)
`endif
  );

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input logic [15:0] p);
    logic [19:0] r;
    int          v;
    v = int'($signed(p));
    if (v < 0) v = -v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input logic [19:0] b);
    logic [4:0] r;
    r = '0;
    for (int d = 1; d < 5; d++) r[d] = ((b >> (4 * d)) == 20'd0);
    return r;
  endfunction

  // Start held for `hold` cycles from the load edge; optional one-cycle re-pulse at cycle `repulse`.
  task automatic convert(input logic [15:0] p, input int hold, input int repulse, input string tag);
    logic [19:0] exp;
    int          dones;
    exp   = ref_bcd(p);
    dones = 0;
    @(negedge Clock);
    iProduct = p;
    Start    = 1'b1;
    for (int j = 1; j <= 35; j++) begin
      @(negedge Clock);
      if (Done) dones++;
      chk({tag, " done"}, {19'd0, Done}, {19'd0, (j == 17)});
      chk({tag, " busy"}, {19'd0, Busy}, {19'd0, (j >= 1 && j <= 16)});
      if (j == 1) begin
        chk({tag, " sign_at_load"}, {19'd0, Sign}, {19'd0, p[15]});
        chk({tag, " hold_prev"}, oBCD, prev_bcd);
      end
      if (j == 17) begin
        chk({tag, " bcd"}, oBCD, exp);
        chk({tag, " sign"}, {19'd0, Sign}, {19'd0, p[15]});
`ifdef LZ_BLANK_EN
        chk({tag, " blank"}, {15'd0, oBlank}, {15'd0, ref_blank(exp)});
`endif
      end
      iProduct = 16'($urandom);
      Start    = (j < hold) || (j == repulse);
    end
    chk({tag, " done_count"}, 20'(dones), 20'd1);
    prev_bcd = exp;
  endtask

  initial begin
    int ai;
    int bi;
    Reset    = 1'b1;
    Start    = 1'b0;
    iProduct = '0;
    repeat (2) @(negedge Clock);
    chk("reset busy", {19'd0, Busy}, 20'd0);
    chk("reset done", {19'd0, Done}, 20'd0);
    chk("reset sign", {19'd0, Sign}, 20'd0);
    chk("reset bcd", oBCD, 20'd0);
`ifdef LZ_BLANK_EN
    chk("reset blank", {15'd0, oBlank}, 20'd0);
`endif
    Reset    = 1'b0;
    prev_bcd = '0;

    convert(16'h0000, 2, 0, "zero");
    convert(16'h7FFF, 2, 0, "max_pos");
    convert(16'h8000, 2, 0, "min_neg");
    convert(16'hFFFF, 2, 0, "minus_one");
    convert(16'hEA8E, 2, 0, "90x-61");
    convert(16'h1F40, 2, 5, "repulse");
    convert(16'hC350, 30, 0, "held_start");

    // Reset in the middle of a conversion discards it.
    @(negedge Clock);
    iProduct = 16'h1234;
    Start    = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge Clock);
      iProduct = 16'($urandom);
      Start    = (j < 2);
    end
    chk("mid busy_before", {19'd0, Busy}, 20'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("mid_reset busy", {19'd0, Busy}, 20'd0);
    chk("mid_reset done", {19'd0, Done}, 20'd0);
    chk("mid_reset bcd", oBCD, 20'd0);
    chk("mid_reset sign", {19'd0, Sign}, 20'd0);
    for (int j = 0; j < 20; j++) begin
      @(negedge Clock);
      chk("mid_reset no_done", {19'd0, Done}, 20'd0);
    end
    prev_bcd = '0;
    convert(16'hEA8E, 2, 0, "after_reset");

    for (int n = 0; n < 16; n++) begin
      ai = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(0, 255)) - 128;
      convert(16'(ai * bi), int'($urandom_range(1, 20)), 0, "rand_mul");
    end
    for (int n = 0; n < 8; n++) begin
      convert(16'($urandom), 2, 0, "rand_word");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_bcd_conv.md
Name: booth_bcd_conv

Overview:
- Downstream stage of the 8-bit Booth multiplier (booth1).
- Takes the signed two's-complement product and converts its magnitude to packed BCD with a separate sign flag, using sequential double-dabble (shift-add-3), one product bit per clock.
- Output drives the HEX display decoders in place of raw hex digits.
- Start/Done handshake matches the multiplier's: Start is level-driven, held for several cycles.

Parameters:
- N, 8, multiplier operand width; product width W = 2N.
- DIGITS, 5, BCD digit count; must satisfy 10^DIGITS > 2^(W-1) (5 for W=16).

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  conversion request; rising edge (sampled) triggers.
- iProduct  input  2N  signed two's-complement product from multiplier.
- Busy  output  1  high while converting.
- Done  output  1  one-cycle pulse when result is valid.
- Sign  output  1  1 = product negative.
- oBCD  output  4*DIGITS  packed BCD magnitude, digit 0 in [3:0].

Behaviour:
- Reset (synchronous, Reset=1 at a clock edge):
  - state IDLE; Busy=0, Done=0, Sign=0, oBCD=0.
  - Start-history register cleared to 0.
  - Overrides everything, including a conversion in progress; the partial result is discarded.
- Start edge detect:
  - start_d registers Start every cycle.
  - start_rise = Start & ~start_d.
  - Only start_rise triggers; holding Start high for many cycles gives exactly one conversion.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start_rise=1, capture Sign <= iProduct[W-1].
  - Capture mag <= |iProduct| as a W-bit unsigned value: two's-complement negate if negative; 0x8000 maps to 0x8000 = 32768.
  - Clear the BCD working register, set bit counter to W, go to SHIFT. Busy=1 from this edge.
  - oBCD/Sign keep the previous result until the new one completes, except that Sign updates at load.
- SHIFT: each edge does one double-dabble step:
  - every working digit >= 5 gets +3 (digit-adjust cells, combinational);
  - then {bcd,mag} shifts left by 1;
  - counter decrements.
  - On the edge where the counter goes 1->0, write the final value to oBCD and go to DONE.
- DONE: Done=1, Busy=0 for exactly one cycle, then IDLE.
- Latency: Done is high in the cycle that starts W edges after the load edge (16 cycles for N=8). The next conversion may start from IDLE the cycle after DONE.
- start_rise while in SHIFT or DONE: ignored, not queued. start_d still tracks, so a Start held through completion does not retrigger.
- iProduct is sampled only at the load edge; changes afterwards have no effect.
- Zero product: Sign=0, oBCD=0.
- No negative zero exists.

Optional Feature:
- Macro LZ_BLANK_EN.
- Defined:
  - adds output oBlank [DIGITS-1:0];
  - bit d = 1 when digit d and all higher digits are 0;
  - bit 0 is always 0, so "0" still displays;
  - registered together with oBCD, reset to 0.
- Undefined: the oBlank port and its logic are absent.
- oBCD and all other timing are identical either way.

Decomposition:
- Package booth_pkg holds:
  - state encoding localparams (IDLE, SHIFT, DONE);
  - BCD digit width constant 4;
  - function bcd_digits(W) returning the minimum digit count, used to check DIGITS at elaboration.
- One sub-module, bcd_digit_adj: combinational 4-bit add-3-if->=5 cell, instantiated DIGITS times via generate.

Test Plan:
- Reset held 2 cycles, then Start 2 cycles with iProduct=0x0000 -> Done 16 cycles after the load edge, oBCD=0x00000, Sign=0, single Done pulse.
- iProduct=0x7FFF -> oBCD=0x32767, Sign=0; iProduct=0x8000 -> oBCD=0x32768, Sign=1.
- iProduct=0xFFFF -> oBCD=0x00001, Sign=1; iProduct=0xEA8E (0x5A*0xC3 = 90*-61) -> oBCD=0x05490, Sign=1.
- Start pulsed again at cycle 5 of a conversion -> ignored; exactly one Done; result matches the first operand. Start held high for 30 cycles -> one conversion only.
- Reset asserted at cycle 8 of SHIFT -> next edge IDLE, Busy=0, oBCD=0, no Done. A fresh Start afterwards converts correctly.
- With LZ_BLANK_EN: 0x05490 -> oBlank=5'b10000; 0 -> 5'b11110; 0x32768 -> 5'b00000.
